fifo_pkt_scheduler: RTL and testbench

Round-robin packet scheduler that shares one downstream packet sink between `NUM_QUEUES` packet FIFOs (`fifomem` instances, 72-bit words, control byte in bits [71:64]). It locks onto one non-empty queue, drains exactly one packet word-by-word, then re-arbitrates. The block drives each FIFO's `fiforead`, forwards words with SOP/EOP marks, and flags framing and length errors.

---
 rtl/fifo_ctrl_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/fifo_pkt_scheduler.sv | 156 +++++++++++++++
 tb/tb_fifo_pkt_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared encodings and word-layout constants for the FIFO
//               packet scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2
  } sched_state_t;

  // Default 72-bit word layout: control byte sits above the 64-bit payload.
  localparam int CTRL_LSB = 64;
  localparam int CTRL_MSB = 71;

  localparam logic [7:0] SOP_MARK = 8'hff;

  localparam int MIN_QUEUES = 2;
  localparam int MAX_QUEUES = 8;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search: first requester strictly
//               after ptr (with wrap). Pointer storage lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(ptr) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        idx     = w_cand;
      end
    end
    any = w_found;
    gnt = w_found ? (N'(1) << idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/fifo_pkt_scheduler.sv
// ============================================================================
// Module      : fifo_pkt_scheduler
// Description : Round-robin packet scheduler draining one whole packet at a
//               time from NUM_QUEUES FIFOs into a single sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pkt_scheduler
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_QUEUES    = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int WIDTH         = DATA_WIDTH + CTRL_WIDTH,
  parameter int MAX_PKT_WORDS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_QUEUES-1:0]       q_empty,
  input  logic [NUM_QUEUES*WIDTH-1:0] q_data,
  output logic [NUM_QUEUES-1:0]       q_read,
  input  logic                        out_rdy,
  output logic                        out_wr,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [NUM_QUEUES-1:0]       grant,
  output logic                        busy,
  input  logic                        err_clr,
  output logic                        err_sop,
  output logic                        err_len
);

  localparam int IDX_W = $clog2(NUM_QUEUES);
  localparam int CNT_W = $clog2(MAX_PKT_WORDS) + 1;

  sched_state_t     r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic [NUM_QUEUES-1:0] w_arb_gnt;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_arb_any;

  logic [WIDTH-1:0]      w_q_word [NUM_QUEUES];
  logic [WIDTH-1:0]      w_word;
  logic [CTRL_WIDTH-1:0] w_ctrl;
  logic                  w_rd_go;
  logic                  w_first;
  logic                  w_last_slot;
  logic                  w_marked_eop;
  logic                  w_eop;

  rr_arbiter #(
    .N     (NUM_QUEUES),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (~q_empty),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_arb_any)
  );

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_unpack
    assign w_q_word[i] = q_data[i*WIDTH +: WIDTH];
  end

  assign w_word = w_q_word[r_idx];
  assign w_ctrl = w_word[WIDTH-1:DATA_WIDTH];

  // Read strobe is combinational so the FIFO's own empty flag gates it this cycle.
  assign w_rd_go = (r_state == ST_READ) && !q_empty[r_idx] && out_rdy && !rst;
  assign q_read  = grant & {NUM_QUEUES{w_rd_go}};
  assign busy    = (r_state != ST_IDLE);

  assign w_first      = (r_cnt == '0);
  assign w_last_slot  = (r_cnt == CNT_W'(MAX_PKT_WORDS - 1));
  assign w_marked_eop = !w_first && (w_ctrl != '0);
  assign w_eop        = w_marked_eop || w_last_slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= IDX_W'(NUM_QUEUES - 1);
      r_idx    <= '0;
      r_cnt    <= '0;
      grant    <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      err_sop  <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      out_wr  <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;

      // A fresh error later in this block overrides the clear.
      if (err_clr) begin
        err_sop <= 1'b0;
        err_len <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            grant   <= w_arb_gnt;
            r_idx   <= w_arb_idx;
            r_ptr   <= w_arb_idx;
            r_cnt   <= '0;
            r_state <= ST_READ;
          end
        end

        ST_READ: begin
          if (w_rd_go) begin
            r_state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          out_data <= w_word;
          out_wr   <= 1'b1;
          out_sop  <= w_first;
          out_eop  <= w_eop;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_first && (w_ctrl == '0)) begin
            err_sop <= 1'b1;
          end
          // Only a forced cut is an overrun; a marked EOP in the last slot is legal.
          if (w_last_slot && !w_marked_eop) begin
            err_len <= 1'b1;
          end
          if (w_eop) begin
            grant   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_READ;
          end
        end

        default: begin
          grant   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_pkt_scheduler.sv
// ============================================================================
// Module      : tb_fifo_pkt_scheduler
// Description : Directed scoreboard bench for fifo_pkt_scheduler with
//               behavioural registered-output FIFOs on every queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_pkt_scheduler;
  import fifo_ctrl_pkg::*;

  localparam int NQ    = 4;
  localparam int W     = 72;
  localparam int MAXW  = 16;
  localparam int DEPTH = 128;

  logic            clk;
  logic            rst;
  logic [NQ-1:0]   q_empty;
  logic [NQ*W-1:0] q_data;
  logic [NQ-1:0]   q_read;
  logic            out_rdy;
  logic            out_wr;
  logic [W-1:0]    out_data;
  logic            out_sop;
  logic            out_eop;
  logic [NQ-1:0]   grant;
  logic            busy;
  logic            err_clr;
  logic            err_sop;
  logic            err_len;

  fifo_pkt_scheduler #(
    .NUM_QUEUES    (NQ),
    .DATA_WIDTH    (64),
    .MAX_PKT_WORDS (MAXW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .q_empty  (q_empty),
    .q_data   (q_data),
    .q_read   (q_read),
    .out_rdy  (out_rdy),
    .out_wr   (out_wr),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .grant    (grant),
    .busy     (busy),
    .err_clr  (err_clr),
    .err_sop  (err_sop),
    .err_len  (err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFOs: registered read data, empty from pointers.
  logic [W-1:0] mem [NQ][DEPTH];
  int wp [NQ];
  int rp [NQ];

  initial begin
    for (int i = 0; i < NQ; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    q_data = '0;
  end

  always_comb begin
    q_empty = '0;
    for (int i = 0; i < NQ; i++) q_empty[i] = (wp[i] == rp[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (q_read[i]) begin
        q_data[i*W +: W] <= mem[i][rp[i]];
        rp[i] <= rp[i] + 1;
      end
    end
  end

  typedef struct {
    logic [W-1:0] d;
    logic         sop;
    logic         eop;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_wr     = 0;
  logic [NQ-1:0] prev_q_read = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int q, input logic [7:0] ctrl, input int idx);
    logic [W-1:0] w;
    w = '0;
    w[CTRL_MSB:CTRL_LSB] = ctrl;
    w[39:32] = 8'(q);
    w[31:0]  = 32'(idx);
    return w;
  endfunction

  task automatic put(input int q, input logic [7:0] ctrl, input int idx);
    mem[q][wp[q]] = mk(q, ctrl, idx);
    wp[q] = wp[q] + 1;
  endtask

  task automatic expect_w(input int q, input logic [7:0] ctrl, input int idx,
                          input logic sop, input logic eop, input int c);
    exp_t e;
    e.d   = mk(q, ctrl, idx);
    e.sop = sop;
    e.eop = eop;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Well-framed packet: SOP_MARK first and last, zero ctrl in between.
  task automatic send_pkt(input int q, input int n, input int base, input bit push_exp);
    logic [7:0] c;
    for (int k = 0; k < n; k++) begin
      c = (k == 0 || k == n - 1) ? SOP_MARK : 8'h00;
      put(q, c, base + k);
      if (push_exp) expect_w(q, c, base + k, k == 0, k == n - 1, -1);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !busy) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $error("FAIL %s timeout pending=%0d busy=%0b", tag, sb.size(), busy);
    end
  endtask

  // Output monitor and protocol watch.
  always @(negedge clk) begin
    if (!rst) begin
      logic bad;
      bad = ($countones(q_read) > 1) || ($countones(grant) > 1) ||
            ((q_read & ~grant) != '0) || ((q_read & q_empty) != '0) ||
            ((q_read != '0) && (prev_q_read != '0));
      chk("protocol", W'(bad), W'(0));
      if (out_wr) begin
        n_wr++;
        if (sb.size() == 0) begin
          chk("unexpected_wr", out_data, '0);
          n_checks++;
          n_fail++;
          $error("FAIL unexpected_wr observed=%0h expected=none", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_sop", W'(out_sop), W'(e.sop));
          chk("out_eop", W'(out_eop), W'(e.eop));
          if (e.cyc >= 0) chk("wr_cycle", W'(cyc), W'(e.cyc));
        end
      end
    end
    prev_q_read = q_read;
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_grant", W'(grant), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_out_wr", W'(out_wr), W'(0));
    chk("rst_q_read", W'(q_read), W'(0));
    chk("rst_err", W'({err_sop, err_len}), W'(0));
    rst = 1'b0;
    step();
  endtask

  initial begin
    int t;
    int base_wr;
    logic [7:0] c;
    rst     = 1'b1;
    out_rdy = 1'b1;
    err_clr = 1'b0;
    step();
    do_reset();

    // Single packet on queue 0 with exact output timing.
    t = cyc;
    send_pkt(0, 4, 100, 0);
    expect_w(0, SOP_MARK, 100, 1, 0, t + 3);
    expect_w(0, 8'h00,    101, 0, 0, t + 5);
    expect_w(0, 8'h00,    102, 0, 0, t + 7);
    expect_w(0, SOP_MARK, 103, 0, 1, t + 9);
    step();
    chk("t1_grant", W'(grant), W'(4'b0001));
    chk("t1_q_read", W'(q_read), W'(4'b0001));
    wait_idle("t1_done", 40);

    // Three queues in round-robin order, then pointer rotation past queue 0.
    do_reset();
    send_pkt(0, 3, 200, 1);
    send_pkt(1, 3, 210, 1);
    send_pkt(2, 3, 220, 1);
    wait_idle("t2_order", 80);
    send_pkt(0, 3, 300, 1);
    send_pkt(1, 3, 310, 0);
    send_pkt(0, 3, 320, 0);
    for (int k = 0; k < 3; k++) begin
      c = (k == 1) ? 8'h00 : SOP_MARK;
      expect_w(1, c, 310 + k, k == 0, k == 2, -1);
    end
    for (int k = 0; k < 3; k++) begin
      c = (k == 1) ? 8'h00 : SOP_MARK;
      expect_w(0, c, 320 + k, k == 0, k == 2, -1);
    end
    wait_idle("t2_rotate", 80);

    // Granted FIFO runs dry mid-packet.
    put(3, SOP_MARK, 400);
    put(3, 8'h00, 401);
    expect_w(3, SOP_MARK, 400, 1, 0, -1);
    expect_w(3, 8'h00,    401, 0, 0, -1);
    expect_w(3, 8'h00,    402, 0, 0, -1);
    expect_w(3, SOP_MARK, 403, 0, 1, -1);
    repeat (10) step();
    chk("t3_busy", W'(busy), W'(1));
    chk("t3_grant", W'(grant), W'(4'b1000));
    chk("t3_q_read", W'(q_read), W'(0));
    put(3, 8'h00, 402);
    put(3, SOP_MARK, 403);
    wait_idle("t3_done", 40);

    // Sink backpressure while reading.
    t = cyc;
    send_pkt(1, 4, 500, 1);
    step();
    step();
    out_rdy = 1'b0;
    base_wr = n_wr;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t4_q_read_held", W'(q_read), W'(0));
    end
    chk("t4_one_in_flight", W'(n_wr), W'(base_wr + 1));
    chk("t4_busy", W'(busy), W'(1));
    out_rdy = 1'b1;
    wait_idle("t4_done", 40);
    chk("t4_no_err", W'({err_sop, err_len}), W'(0));

    // Over-length packet: forced cut at MAXW words, remainder re-framed.
    for (int k = 0; k < 20; k++) begin
      c = (k == 0 || k == 19) ? SOP_MARK : 8'h00;
      put(2, c, 600 + k);
      expect_w(2, c, 600 + k, (k == 0) || (k == MAXW), (k == MAXW - 1) || (k == 19), -1);
    end
    wait_idle("t5_done", 120);
    chk("t5_err_len", W'(err_len), W'(1));
    chk("t5_err_sop", W'(err_sop), W'(1));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_err_clr", W'({err_sop, err_len}), W'(0));

    // Reset while a word is in CHECK.
    send_pkt(1, 4, 700, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t6_out_wr", W'(out_wr), W'(0));
    chk("t6_out_data", out_data, '0);
    chk("t6_marks", W'({out_sop, out_eop}), W'(0));
    chk("t6_grant", W'(grant), W'(0));
    chk("t6_busy", W'(busy), W'(0));
    chk("t6_q_read", W'(q_read), W'(0));
    step();
    rst = 1'b0;
    send_pkt(0, 3, 800, 1);
    expect_w(1, 8'h00,    701, 1, 0, -1);
    expect_w(1, 8'h00,    702, 0, 0, -1);
    expect_w(1, SOP_MARK, 703, 0, 1, -1);
    step();
    chk("t6_q0_first", W'(grant), W'(4'b0001));
    wait_idle("t6_done", 60);
    chk("t6_err_sop", W'(err_sop), W'(1));
    chk("t6_err_len", W'(err_len), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
